// File: rtl/output_drain_ctrl.sv
// Drains rows from the per-column accumulator banks into the output buffer: issues column reads,
// optionally skewed per column, and replays them as output writes RD_LAT cycles later.
module output_drain_ctrl #(
  parameter int unsigned SYS_COL   = 16,
  parameter int unsigned ACCUM_ROW = 64,
  parameter int unsigned OUT_DEPTH = 256,
  parameter int unsigned ROW_W     = 16,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned ACC_AW   = $clog2(ACCUM_ROW),
  localparam int unsigned OUT_AW   = $clog2(OUT_DEPTH),
  localparam int unsigned CNT_W    = ACC_AW + 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [OUT_AW-1:0]               base_addr,
  input  logic [OUT_AW-1:0]               stride,
  input  logic [ROW_W-1:0]                num_row,
  input  logic                            skew_en,
  input  logic                            stall,
  output logic [SYS_COL-1:0]              accum_rd_en,
  output logic [SYS_COL-1:0][ACC_AW-1:0]  accum_rd_addr,
  output logic [SYS_COL-1:0]              output_wr_en,
  output logic [SYS_COL-1:0][OUT_AW-1:0]  output_wr_addr,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                                   state_q, state_d;
  logic [CNT_W-1:0]                         row_q, row_d, n_q, n_d;
  logic [OUT_AW-1:0]                        stride_q, stride_d, wa_q, wa_d;
  logic                                     skew_q, skew_d, err_q, err_d;
  logic                                     busy_q, busy_d, done_q, done_d;
  logic [SYS_COL-1:0]                       rd_v_q, rd_v_d;
  logic [SYS_COL-1:0][ACC_AW-1:0]           rd_row_q, rd_row_d;
  logic [SYS_COL-1:0][OUT_AW-1:0]           rd_wa_q, rd_wa_d;
  logic [RD_LAT-1:0][SYS_COL-1:0]           dl_v_q, dl_v_d;
  logic [RD_LAT-1:0][SYS_COL-1:0][OUT_AW-1:0] dl_wa_q, dl_wa_d;

  logic              iss_v;
  logic [ACC_AW-1:0] iss_row;
  logic [OUT_AW-1:0] iss_wa;
  logic              freeze, pipe_busy, ovf;

  // Stall only matters while the engine is moving; it holds every stage and masks the enables.
  assign freeze = stall && (state_q == StIssue || state_q == StDrain);
  assign ovf    = num_row > ROW_W'(ACCUM_ROW);

  always_comb begin
    pipe_busy = |rd_v_q;
    for (int k = 0; k < int'(RD_LAT) - 1; k++) pipe_busy = pipe_busy | (|dl_v_q[k]);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    n_d      = n_q;
    stride_d = stride_q;
    skew_d   = skew_q;
    wa_d     = wa_q;
    err_d    = err_q;
    iss_v    = 1'b0;
    iss_row  = '0;
    iss_wa   = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          stride_d = stride;
          skew_d   = skew_en;
          err_d    = ovf;
          n_d      = ovf ? CNT_W'(ACCUM_ROW) : CNT_W'(num_row);
          if (n_d == '0) begin
            state_d = StDone;
          end else begin
            // Row 0 is issued on the accepting edge so it is visible in the first busy cycle.
            iss_v   = 1'b1;
            iss_wa  = base_addr;
            row_d   = CNT_W'(1);
            wa_d    = base_addr + stride;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (!stall) begin
          if (row_q < n_q) begin
            iss_v   = 1'b1;
            iss_row = row_q[ACC_AW-1:0];
            iss_wa  = wa_q;
            wa_d    = wa_q + stride_q;
          end
          row_d = row_q + CNT_W'(1);
          if (row_q + CNT_W'(1) >= n_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!stall && !pipe_busy) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StIssue) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_comb begin
    logic [SYS_COL-1:0]             src_v;
    logic [SYS_COL-1:0][OUT_AW-1:0] src_wa;
    int unsigned                    km1;
    rd_v_d   = rd_v_q;
    rd_row_d = rd_row_q;
    rd_wa_d  = rd_wa_q;
    dl_v_d   = dl_v_q;
    dl_wa_d  = dl_wa_q;
    src_v    = '0;
    src_wa   = '0;
    km1      = 0;
    if (!freeze) begin
      if (skew_d) begin
        rd_v_d   = {rd_v_q[SYS_COL-2:0], iss_v};
        rd_row_d = {rd_row_q[SYS_COL-2:0], iss_row};
        rd_wa_d  = {rd_wa_q[SYS_COL-2:0], iss_wa};
      end else begin
        rd_v_d   = {SYS_COL{iss_v}};
        rd_row_d = {SYS_COL{iss_row}};
        rd_wa_d  = {SYS_COL{iss_wa}};
      end
      for (int k = 0; k < int'(RD_LAT); k++) begin
        km1    = (k == 0) ? 0 : k - 1;
        src_v  = (k == 0) ? rd_v_q : dl_v_q[km1];
        src_wa = (k == 0) ? rd_wa_q : dl_wa_q[km1];
        dl_v_d[k] = src_v;
        // Write addresses only advance with valid data so the last address stays on the port.
        for (int c = 0; c < int'(SYS_COL); c++) begin
          if (src_v[c]) dl_wa_d[k][c] = src_wa[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      row_q    <= '0;
      n_q      <= '0;
      stride_q <= '0;
      wa_q     <= '0;
      skew_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_v_q   <= '0;
      rd_row_q <= '0;
      rd_wa_q  <= '0;
      dl_v_q   <= '0;
      dl_wa_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      n_q      <= n_d;
      stride_q <= stride_d;
      wa_q     <= wa_d;
      skew_q   <= skew_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_v_q   <= rd_v_d;
      rd_row_q <= rd_row_d;
      rd_wa_q  <= rd_wa_d;
      dl_v_q   <= dl_v_d;
      dl_wa_q  <= dl_wa_d;
    end
  end

  assign accum_rd_en    = rd_v_q & {SYS_COL{~freeze}};
  assign accum_rd_addr  = rd_row_q;
  assign output_wr_en   = dl_v_q[RD_LAT-1] & {SYS_COL{~freeze}};
  assign output_wr_addr = dl_wa_q[RD_LAT-1];
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
